// File: rtl/prio_merge_arb_pkg.sv
// prio_pkg: shared word layout for the priority merge path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default output width DW, PRIO_BIT position, PRIO_HI/PRIO_LO tags,
//           prio_word_t = {prio, payload}.
package prio_pkg;

  localparam int DW       = 33;
  localparam int PRIO_BIT = DW - 1;

  localparam logic PRIO_HI = 1'b1;
  localparam logic PRIO_LO = 1'b0;

  typedef struct packed {
    logic          prio;
    logic [DW-2:0] payload;
  } prio_word_t;

endpackage

// File: rtl/prio_merge_arb_if.sv
// prio_merge_arb_if: bundles the high/low source channels and the merged output channel.
// Latency: n/a (wires only).
// Backpressure: carries hi_rdy_o/lo_rdy_o upstream and rdy_i from the downstream FIFO.
// Modports: slave  = merge block side (sources in, merged word out)
//           master = environment side (drives sources, consumes merged word)
interface prio_merge_arb_if #(
  parameter int DW = prio_pkg::DW
);

  logic [DW-2:0] hi_data_in;
  logic          hi_vld_i;
  logic          hi_rdy_o;
  logic [DW-2:0] lo_data_in;
  logic          lo_vld_i;
  logic          lo_rdy_o;
  logic [DW-1:0] data_out;
  logic          vld_o;
  logic          rdy_i;
  logic          starve_evt_o;

  modport slave (
    input  hi_data_in, hi_vld_i, lo_data_in, lo_vld_i, rdy_i,
    output hi_rdy_o, lo_rdy_o, data_out, vld_o, starve_evt_o
  );

  modport master (
    output hi_data_in, hi_vld_i, lo_data_in, lo_vld_i, rdy_i,
    input  hi_rdy_o, lo_rdy_o, data_out, vld_o, starve_evt_o
  );

endinterface

// File: rtl/prio_merge_arb_stream_reg.sv
// stream_reg: one-deep registered valid/ready stage.
// Latency: 1 cycle input accept to output valid; full throughput while out_rdy_i=1.
// Backpressure: in_rdy_o = !out_vld || out_rdy_i (forced 0 in reset); output word held while stalled.
// Ports: clk/rst (sync, active-high), in_vld_i/in_rdy_o/in_dat_i upstream,
//        out_vld_o/out_rdy_i/out_dat_o downstream.
module stream_reg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output logic [W-1:0] out_dat_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  // A draining word and a new word may swap in the same cycle, so free
  // space includes "downstream is taking the current word right now".
  assign in_rdy_o = !rst && (!vld_q || out_rdy_i);

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_vld_i && in_rdy_o) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      // Drained with nothing new: drop valid, keep last data visible.
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

endmodule

// File: rtl/prio_merge_arb.sv
// prio_merge_arb: merges high/low 32-bit streams into one {prio, payload} stream,
//   fixed priority high over low with a starvation guard after MAX_HI contended high grants.
// Latency: 1 cycle input transfer to vld_o; one word per cycle while rdy_i=1.
// Backpressure: both input readies drop while vld_o=1 and rdy_i=0; data_out held.
// Ports: clk, rst (sync active-high), bus (slave modport: hi_*, lo_* sources,
//        data_out/vld_o/rdy_i merged output, starve_evt_o forced-low pulse).
module prio_merge_arb
  import prio_pkg::*;
#(
  parameter int DW     = prio_pkg::DW,
  parameter int MAX_HI = 4
) (
  input logic             clk,
  input logic             rst,
  prio_merge_arb_if.slave bus
);

  if (MAX_HI < 1 || MAX_HI > 255 || DW < 2) begin : g_param_check
    $error("prio_merge_arb: MAX_HI must be 1..255 and DW >= 2");
  end

  localparam int             SW       = $clog2(MAX_HI + 1);
  localparam logic [SW-1:0]  MAX_HI_S = SW'(MAX_HI);

  logic [SW-1:0] streak_q, streak_d;
  logic          starve_q, starve_d;

  logic          forced;
  logic          grant_hi, grant_lo;
  logic          out_free;
  logic          hi_xfer, lo_xfer;
  logic [DW-1:0] sel_word;

  // Low is forced only when both compete and high has used its full streak.
  assign forced   = bus.hi_vld_i && bus.lo_vld_i && (streak_q == MAX_HI_S);
  assign grant_hi = bus.hi_vld_i && !forced;
  assign grant_lo = bus.lo_vld_i && (!bus.hi_vld_i || forced);

  assign sel_word = grant_hi ? {PRIO_HI, bus.hi_data_in} : {PRIO_LO, bus.lo_data_in};

  stream_reg #(
    .W (DW)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (grant_hi || grant_lo),
    .in_rdy_o  (out_free),
    .in_dat_i  (sel_word),
    .out_vld_o (bus.vld_o),
    .out_rdy_i (bus.rdy_i),
    .out_dat_o (bus.data_out)
  );

  assign bus.hi_rdy_o = out_free && grant_hi;
  assign bus.lo_rdy_o = out_free && grant_lo;

  assign hi_xfer = bus.hi_vld_i && bus.hi_rdy_o;
  assign lo_xfer = bus.lo_vld_i && bus.lo_rdy_o;

  // Streak counts only high grants that made low wait; an uncontended
  // high grant or any low grant clears it.
  always_comb begin
    streak_d = streak_q;
    starve_d = 1'b0;
    if (hi_xfer) begin
      if (!bus.lo_vld_i) begin
        streak_d = '0;
      end else if (streak_q != MAX_HI_S) begin
        streak_d = streak_q + SW'(1);
      end
    end else if (lo_xfer) begin
      streak_d = '0;
      starve_d = forced;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
      starve_q <= 1'b0;
    end else begin
      streak_q <= streak_d;
      starve_q <= starve_d;
    end
  end

  assign bus.starve_evt_o = starve_q;

endmodule

// File: tb/tb_prio_merge_arb.sv
// tb_prio_merge_arb: directed vectors for prio_merge_arb (DW=33, MAX_HI=4).
// Inputs driven and outputs sampled on the falling edge.
module tb_prio_merge_arb;
  import prio_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  prio_merge_arb_if #(.DW(33)) bus ();

  prio_merge_arb #(
    .DW     (33),
    .MAX_HI (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  prio_word_t w;
  logic exp_prio   [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic exp_starve [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset with both sources valid.
    rst            = 1'b1;
    bus.hi_vld_i   = 1'b1;
    bus.lo_vld_i   = 1'b1;
    bus.hi_data_in = 32'h0BAD_0001;
    bus.lo_data_in = 32'h0BAD_0002;
    bus.rdy_i      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_vec("rst_vld",    bus.vld_o,        0);
      chk_vec("rst_data",   bus.data_out,     0);
      chk_vec("rst_hi_rdy", bus.hi_rdy_o,     0);
      chk_vec("rst_lo_rdy", bus.lo_rdy_o,     0);
      chk_vec("rst_starve", bus.starve_evt_o, 0);
    end

    // High only, first transfer after release.
    rst            = 1'b0;
    bus.lo_vld_i   = 1'b0;
    bus.hi_data_in = 32'h1234_5678;
    #1;
    chk_vec("hi_rdy_pre", bus.hi_rdy_o, 1);
    chk_vec("vld_pre",    bus.vld_o,    0);
    step();
    chk_vec("hi_data",   bus.data_out,     33'h1_1234_5678);
    chk_vec("hi_vld",    bus.vld_o,        1);
    chk_vec("hi_starve", bus.starve_evt_o, 0);

    // Low only.
    bus.hi_vld_i   = 1'b0;
    bus.lo_vld_i   = 1'b1;
    bus.lo_data_in = 32'hDEAD_BEEF;
    #1;
    chk_vec("lo_rdy_pre", bus.lo_rdy_o, 1);
    chk_vec("hi_rdy_off", bus.hi_rdy_o, 0);
    step();
    chk_vec("lo_data",   bus.data_out,     33'h0_DEAD_BEEF);
    chk_vec("lo_starve", bus.starve_evt_o, 0);

    // Starvation guard: both always valid, four highs then a forced low.
    bus.hi_vld_i   = 1'b1;
    bus.lo_vld_i   = 1'b1;
    bus.hi_data_in = 32'hAAAA_0000;
    bus.lo_data_in = 32'hBBBB_0000;
    for (int i = 0; i < 10; i++) begin
      step();
      w = bus.data_out;
      chk_vec($sformatf("starve_prio%0d", i), w.prio, exp_prio[i]);
      chk_vec($sformatf("starve_pay%0d", i), w.payload,
              exp_prio[i] ? 32'hAAAA_0000 : 32'hBBBB_0000);
      chk_vec($sformatf("starve_evt%0d", i), bus.starve_evt_o, exp_starve[i]);
      chk_vec($sformatf("starve_vld%0d", i), bus.vld_o, 1);
    end

    // Backpressure: load 0_AAAA5555, then stall for 5 cycles.
    bus.hi_vld_i   = 1'b0;
    bus.lo_data_in = 32'hAAAA_5555;
    step();
    chk_vec("bp_load", bus.data_out, 33'h0_AAAA_5555);
    bus.rdy_i      = 1'b0;
    bus.hi_vld_i   = 1'b1;
    bus.hi_data_in = 32'h0000_BEEF;
    bus.lo_data_in = 32'h0000_CAFE;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_vec($sformatf("bp_hi_rdy%0d", i), bus.hi_rdy_o, 0);
      chk_vec($sformatf("bp_lo_rdy%0d", i), bus.lo_rdy_o, 0);
      step();
      chk_vec($sformatf("bp_data%0d", i), bus.data_out, 33'h0_AAAA_5555);
      chk_vec($sformatf("bp_vld%0d", i),  bus.vld_o,    1);
    end
    bus.rdy_i = 1'b1;
    #1;
    chk_vec("bp_rel_hi_rdy", bus.hi_rdy_o, 1);
    chk_vec("bp_rel_lo_rdy", bus.lo_rdy_o, 0);
    step();
    chk_vec("bp_next_data", bus.data_out, 33'h1_0000_BEEF);
    chk_vec("bp_next_vld",  bus.vld_o,    1);
    bus.hi_vld_i = 1'b0;
    step();
    chk_vec("bp_lo_data", bus.data_out, 33'h0_0000_CAFE);
    chk_vec("bp_lo_vld",  bus.vld_o,    1);

    // Mid-operation reset with streak at 3.
    bus.hi_vld_i   = 1'b1;
    bus.lo_vld_i   = 1'b1;
    bus.hi_data_in = 32'h1111_1111;
    bus.lo_data_in = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_vec($sformatf("mr_pre_data%0d", i), bus.data_out, 33'h1_1111_1111);
    end
    rst = 1'b1;
    #1;
    chk_vec("mr_hi_rdy", bus.hi_rdy_o, 0);
    chk_vec("mr_lo_rdy", bus.lo_rdy_o, 0);
    step();
    chk_vec("mr_vld",    bus.vld_o,        0);
    chk_vec("mr_data",   bus.data_out,     0);
    chk_vec("mr_starve", bus.starve_evt_o, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_vec($sformatf("mr_data%0d", i), bus.data_out,
              (i < 4) ? 33'h1_1111_1111 : 33'h0_2222_2222);
      chk_vec($sformatf("mr_evt%0d", i), bus.starve_evt_o, (i == 4) ? 1 : 0);
    end

    // Drain with nothing new: valid drops, data kept.
    bus.hi_vld_i = 1'b0;
    bus.lo_vld_i = 1'b0;
    step();
    chk_vec("drain_vld",  bus.vld_o,    0);
    chk_vec("drain_data", bus.data_out, 33'h0_2222_2222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/prio_merge_arb.md
Name: prio_merge_arb

Overview:
- Upstream feeder of fifo_priority.
- Merges two 32-bit source streams, high and low class, into one DW-bit stream: MSB is the priority bit (1 = high), low DW-1 bits are payload.
- Arbitrates fixed-priority high over low, with a starvation guard that forces a low grant after MAX_HI consecutive contended high grants.
- Output is registered, one word deep, and drives fifo_priority's data_in/vld_i/rdy_o channel.

Parameters:
- DW, 33, output word width including priority MSB; payload width is DW-1.
- MAX_HI, 4, max consecutive high grants while low is waiting; legal range 1..255.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- hi_data_in  in  DW-1  high-class payload.
- hi_vld_i  in  1  high-class valid.
- hi_rdy_o  out  1  high-class ready.
- lo_data_in  in  DW-1  low-class payload.
- lo_vld_i  in  1  low-class valid.
- lo_rdy_o  out  1  low-class ready.
- data_out  out  DW  {prio, payload} to the downstream FIFO.
- vld_o  out  1  output valid (registered).
- rdy_i  in  1  downstream ready.
- starve_evt_o  out  1  one-cycle pulse (registered) when a forced low grant transfers.

Behaviour:
- Reset values: vld_o=0, data_out=0, starve_evt_o=0, streak=0.
- A reset in the middle of operation drops any held output word. Ready outputs are 0 during reset.
- Transfer on any channel occurs when vld and rdy are both 1 at a rising edge.
- Sources hold data/valid stable until accepted. The block does not check this.
- out_free = !vld_o || rdy_i, combinational.
- hi_rdy_o = out_free && grant_hi; lo_rdy_o = out_free && grant_lo. Ready may depend on valid; valid never depends on ready.
- Grant selection, combinational, evaluated every cycle:
  - Only hi_vld_i: grant_hi.
  - Only lo_vld_i: grant_lo.
  - Both valid and streak < MAX_HI: grant_hi.
  - Both valid and streak == MAX_HI: grant_lo (forced).
  - Neither valid: no grant.
- Output register update:
  - On a hi transfer: data_out <= {1'b1, hi_data_in}, vld_o <= 1.
  - On a lo transfer: data_out <= {1'b0, lo_data_in}, vld_o <= 1.
  - Else if rdy_i: vld_o <= 0, and data_out keeps its last value.
- Latency: input transfer to vld_o is 1 cycle. Back-to-back transfers every cycle are sustained while rdy_i=1.
- Backpressure: while vld_o=1 and rdy_i=0, both input readies are 0 and data_out holds stable.
- Streak counter, width clog2(MAX_HI+1), updated only on a transfer:
  - hi transfer with lo_vld_i=1: streak+1, saturating at MAX_HI.
  - hi transfer with lo_vld_i=0: streak <= 0.
  - any lo transfer: streak <= 0.
  - No transfer: streak holds.
- starve_evt_o <= 1 for exactly the cycle after a lo transfer made under the forced condition; 0 otherwise.
- Simultaneous output drain and new transfer in the same cycle: the new word replaces the old one, vld_o stays 1, and no bubble is inserted.
- Elaboration assertion: MAX_HI in 1..255 and DW >= 2.

Decomposition:
- Package prio_pkg holds:
  - constant PRIO_BIT = DW-1;
  - localparams PRIO_HI = 1'b1 and PRIO_LO = 1'b0;
  - typedef prio_word_t = struct packed {logic prio; logic [DW-2:0] payload;}.
- Arbitration and the streak counter stay in prio_merge_arb.
- Natural sub-module: stream_reg, a one-deep valid/ready output register, parameterised by width and reused elsewhere.

Test Plan:
- Reset: assert rst for 3 cycles with both sources valid -> vld_o=0, hi_rdy_o=lo_rdy_o=0, data_out=0; after release, first word appears 1 cycle after the first transfer.
- Hi only: hi_data_in=0x12345678, hi_vld_i=1, rdy_i=1 -> next cycle data_out=0x1_12345678, vld_o=1; streak stays 0.
- Starvation (MAX_HI=4): both sources continuously valid, rdy_i=1 -> output priority bits 1,1,1,1,0,1,1,1,1,0,...; starve_evt_o pulses once per low word.
- Backpressure: vld_o=1 holding 0x0_AAAA5555, rdy_i=0 for 5 cycles -> data_out stable, both input readies 0; rdy_i=1 -> drain, next word follows with no bubble.
- Lo only: lo_data_in=0xDEADBEEF, rdy_i=1 -> data_out=0x0_DEADBEEF; starve_evt_o stays 0.
- Mid-operation reset: both valid, streak=3, assert rst for 1 cycle -> vld_o=0, streak=0; next 4 contended grants go to high before a forced low grant.
